addsub_serial: RTL
==================

// Module: addsub_serial
// PURPOSE
//  Parametrised multi-cycle unsigned adder/subtractor for the SAP-1 ALU path.
//  Processes DIGIT bits per clock, so area scales with DIGIT, not WIDTH.
//  Accepts operands on a start/done handshake and holds result + flags until the next op.
//  Sits between the A/B registers and the bus driver, in place of the combinational 8-bit adder.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  4  bits processed per RUN cycle; N = WIDTH/DIGIT cycles per op (1 <= DIGIT <= WIDTH)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request op; sampled only in IDLE or DONE
//  sub    in   1      0 = a+b, 1 = a-b (a + ~b + 1); sampled with start
//  a      in   WIDTH  operand A; sampled with start
//  b      in   WIDTH  operand B; sampled with start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: s/carry/zero valid and updated
//  s      out  WIDTH  result, modulo 2^WIDTH
//  carry  out  1      add: carry-out; sub: 1 = no borrow (a >= b), 0 = borrow
//  zero   out  1      s == 0
// BEHAVIOUR
//  - Reset (async, any state incl. mid-RUN): state=IDLE, busy=0, done=0, s=0, carry=0, zero=0,
//    digit counter=0, operand/shift registers=0. Partial result is discarded.
//  - FSM IDLE -> RUN on start; RUN stays N cycles; RUN -> DONE after digit N-1; DONE -> IDLE,
//    or DONE -> RUN if start is high in DONE (back-to-back, no bubble).
//  - Accept edge: latch a, b^{WIDTH{sub}}, carry-in = sub, counter=0.
//  - Each RUN edge: add digit [cnt*DIGIT +: DIGIT] of a and b' with running carry; write the
//    result digit; update running carry; cnt++.
//  - Latency: done is high in the cycle following the N-th edge after the accept edge;
//    s/carry/zero change only on that edge.
//  - Outputs s/carry/zero hold their values from DONE until the next op completes;
//    they do not show partial sums during RUN.
//  - start while busy: ignored, no error, no queueing. a/b/sub may change freely during RUN.
//  - Wrap-around: 0xFF+0x01 (WIDTH=8) -> s=0x00, carry=1, zero=1.
//  - DIGIT == WIDTH: N=1, one RUN cycle; behaviour otherwise identical.
// CONFIGURATION
//  Macro ADDSUB_SIGNED_OVF_EN:
//   defined   -> extra output ovf (1 bit): two's-complement overflow = carry into MSB ^ carry out
//                of MSB, registered with s; reset 0; valid on done, held like s.
//   undefined -> port ovf absent; no MSB carry tracking logic.
// STRUCTURE
//  - Package addsub_pkg: state enum {IDLE, RUN, DONE}, localparam for N and counter width
//    ($clog2(N) min 1), op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
//  - Sub-module digit_adder: combinational DIGIT-bit ripple adder (x, y, cin -> sum, cout,
//    c_msb for ovf). Top owns FSM, counter, operand regs, result regs.
// TESTING
//  - WIDTH=8, DIGIT=4: a=0x01 b=0x02 add -> done after 2 RUN cycles, s=0x03 carry=0 zero=0.
//  - a=0x0F b=0x01 add -> s=0x10 (carry crosses digit boundary); a=0xFF b=0x01 -> s=0x00 carry=1 zero=1.
//  - sub: a=0x05 b=0x03 -> s=0x02 carry=1; a=0x03 b=0x05 -> s=0xFE carry=0; a=b=0x42 -> s=0 zero=1.
//  - start pulsed again during RUN with other operands -> ignored, first result returned;
//    start held high in DONE -> next op accepted with no idle cycle.
//  - rst_n low mid-RUN -> all outputs 0 immediately; next op after release computes correctly.
//  - WIDTH=16 DIGIT=1 and DIGIT=16: 0x7FFF+0x0001 -> s=0x8000 carry=0, latency 16 vs 1;
//    with ADDSUB_SIGNED_OVF_EN ovf=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int addsub_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter needs at least one bit even when a single digit covers the word.
  function automatic int addsub_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int N_DEF     = addsub_n(8, 4);
  localparam int CNT_W_DEF = addsub_cnt_w(N_DEF);

endpackage

// File: rtl/addsub_serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder; c_msb (carry into the top bit) exists
// only when ADDSUB_SIGNED_OVF_EN is defined.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
`ifdef ADDSUB_SIGNED_OVF_EN
  ,
  output logic             c_msb
`endif
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1]  = (x[gi] & y[gi]) | (x[gi] & c[gi]) | (y[gi] & c[gi]);
  end

  assign cout = c[DIGIT];
`ifdef ADDSUB_SIGNED_OVF_EN
  assign c_msb = c[DIGIT-1];
`endif

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle unsigned adder/subtractor, DIGIT bits per RUN cycle.
// Define ADDSUB_SIGNED_OVF_EN to add the registered two's-complement ovf output.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             zero
`ifdef ADDSUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = addsub_n(WIDTH, DIGIT);
  localparam int CW = addsub_cnt_w(N);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             rc_q, rc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] x_dig, y_dig, sum_dig;
  logic             cout_dig;
  logic [WIDTH-1:0] res;

  assign x_dig = a_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign y_dig = b_q[int'(cnt_q)*DIGIT +: DIGIT];

`ifdef ADDSUB_SIGNED_OVF_EN
  logic c_msb_dig;
  logic ovf_q, ovf_d;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (x_dig),
    .y     (y_dig),
    .cin   (rc_q),
    .sum   (sum_dig),
    .cout  (cout_dig),
    .c_msb (c_msb_dig)
  );
`else
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (x_dig),
    .y    (y_dig),
    .cin  (rc_q),
    .sum  (sum_dig),
    .cout (cout_dig)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rc_d    = rc_q;
    s_d     = s_q;
    carry_d = carry_q;
    zero_d  = zero_q;
`ifdef ADDSUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    res     = acc_q;
    res[int'(cnt_q)*DIGIT +: DIGIT] = sum_dig;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1: invert b once here, seed carry-in with 1.
          state_d = RUN;
          a_d     = a;
          b_d     = (sub == OP_SUB) ? ~b : b;
          rc_d    = (sub == OP_SUB);
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = res;
        rc_d  = cout_dig;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          s_d     = res;
          carry_d = cout_dig;
          zero_d  = (res == '0);
`ifdef ADDSUB_SIGNED_OVF_EN
          ovf_d   = c_msb_dig ^ cout_dig;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rc_q    <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ADDSUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rc_q    <= rc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
`ifdef ADDSUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign s     = s_q;
  assign carry = carry_q;
  assign zero  = zero_q;
`ifdef ADDSUB_SIGNED_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
